// File: rtl/cache_arb_pkg.sv
// Shared types, defaults and helpers for the cache request arbiter.
// Optional statistics are enabled by defining CACHE_ARB_STATS_EN.
package cache_arb_pkg;

  localparam int unsigned DefNumReq         = 4;
  localparam int unsigned DefTagsWidth      = 48;
  localparam int unsigned DefDataPortSize   = 512;
  localparam int unsigned DefMaxOutstanding = 4;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } arb_state_e;

  // Bits needed to represent value (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    while (bits < 32 && (32'd1 << bits) <= value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester, response and cache-frontend handshakes of the cache request arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface cache_req_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned TAGS_WIDTH     = DefTagsWidth,
  parameter int unsigned DATA_PORT_SIZE = DefDataPortSize
) ();

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][TAGS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [DATA_PORT_SIZE-1:0]          rsp_data;
  logic                               cache_addr_valid;
  logic                               cache_addr_ready;
  logic [TAGS_WIDTH-1:0]              cache_addr_data;
  logic                               cache_data_valid;
  logic                               cache_data_ready;
  logic [DATA_PORT_SIZE-1:0]          cache_data_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, cache_addr_ready, cache_data_valid, cache_data_data,
    output req_ready, rsp_valid, rsp_data, cache_addr_valid, cache_addr_data, cache_data_ready
  );

  modport master (
    output req_valid, req_addr, rsp_ready, cache_addr_ready, cache_data_valid, cache_data_data,
    input  req_ready, rsp_valid, rsp_data, cache_addr_valid, cache_addr_data, cache_data_ready
  );

endinterface

// File: rtl/cache_arb_id_fifo.sv
// In-order FIFO of requester indices for issued-but-unanswered cache lookups.
module cache_arb_id_fifo
  import cache_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [clogb2(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache lookup port between NUM_REQ requesters, with
// in-order response routing. Define CACHE_ARB_STATS_EN to add grant/full-stall counters.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DefNumReq,
  parameter int unsigned TAGS_WIDTH      = DefTagsWidth,
  parameter int unsigned DATA_PORT_SIZE  = DefDataPortSize,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef CACHE_ARB_STATS_EN
  output logic [NUM_REQ-1:0][31:0]  stat_grant_cnt,
  output logic [31:0]               stat_full_cycles,
`endif
  cache_req_arbiter_if.slave        bus
);

  localparam int unsigned IdxW = clogb2(NUM_REQ - 1);
  localparam int unsigned CntW = clogb2(MAX_OUTSTANDING);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [TAGS_WIDTH-1:0] addr_q, addr_d;

  logic [IdxW-1:0] rr_win, fifo_head;
  logic            rr_found, can_grant, grant, push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count, out_count;
  int unsigned     cand;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_win   = IdxW'(cand);
      end
    end
  end

  // The in-flight ISSUE lookup counts against the limit so the FIFO can never overflow.
  assign out_count = fifo_count + CntW'(state_q == StIssue);
  assign can_grant = rr_found && !fifo_full && (out_count < CntW'(MAX_OUTSTANDING));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    grant    = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_grant) begin
          grant   = 1'b1;
          idx_d   = rr_win;
          addr_d  = bus.req_addr[rr_win];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.cache_addr_ready) begin
          push     = 1'b1;
          rr_ptr_d = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.cache_addr_valid = (state_q == StIssue);
  assign bus.cache_addr_data  = addr_q;
  assign bus.rsp_data         = bus.cache_data_data;
  assign pop                  = bus.cache_data_valid && bus.cache_data_ready;

  // Handshake outputs are gated by rst so nothing is accepted in the reset cycle.
  always_comb begin
    bus.req_ready        = '0;
    bus.rsp_valid        = '0;
    bus.cache_data_ready = 1'b0;
    if (grant && !rst) bus.req_ready[rr_win] = 1'b1;
    if (!fifo_empty && !rst) begin
      bus.rsp_valid[fifo_head] = bus.cache_data_valid;
      bus.cache_data_ready     = bus.rsp_ready[fifo_head];
    end
  end

  cache_arb_id_fifo #(
    .WIDTH (IdxW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (idx_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

`ifdef CACHE_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              full_cyc_q, full_cyc_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    full_cyc_d  = full_cyc_q;
    if (push && grant_cnt_q[idx_q] != '1) grant_cnt_d[idx_q] = grant_cnt_q[idx_q] + 32'd1;
    if (state_q == StIdle && |bus.req_valid && out_count == CntW'(MAX_OUTSTANDING) &&
        full_cyc_q != '1) begin
      full_cyc_d = full_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      full_cyc_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      full_cyc_q  <= full_cyc_d;
    end
  end

  assign stat_grant_cnt   = grant_cnt_q;
  assign stat_full_cycles = full_cyc_q;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter: stimulus queues expected issues/responses,
// a monitor pops and compares on each DUT handshake. Stats test needs CACHE_ARB_STATS_EN.
module tb_cache_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TW = 48;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_arbiter_if #(.NUM_REQ(NR), .TAGS_WIDTH(TW), .DATA_PORT_SIZE(DW)) bus ();

`ifdef CACHE_ARB_STATS_EN
  logic [NR-1:0][31:0] stat_grant_cnt;
  logic [31:0]         stat_full_cycles;
`endif

  cache_req_arbiter #(
    .NUM_REQ         (NR),
    .TAGS_WIDTH      (TW),
    .DATA_PORT_SIZE  (DW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef CACHE_ARB_STATS_EN
    .stat_grant_cnt   (stat_grant_cnt),
    .stat_full_cycles (stat_full_cycles),
`endif
    .bus              (bus)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  logic [TW-1:0] exp_addr_q[$];
  rsp_t          exp_rsp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [TW-1:0] taddr[NR];
  int            n_chk  = 0;
  int            n_pass = 0;
  bit            resp_en = 1'b0;

  function automatic logic [DW-1:0] rsp_of(input logic [TW-1:0] a);
    return {8{a, 16'hC0DE}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_grant(input int idx);
    rsp_t r;
    r.idx  = idx;
    r.data = rsp_of(taddr[idx]);
    exp_addr_q.push_back(taddr[idx]);
    exp_rsp_q.push_back(r);
  endtask

  task automatic wait_issued(input string name);
    int budget;
    budget = 100;
    while (exp_addr_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, DW'(exp_addr_q.size()), '0);
  endtask

  task automatic wait_rsp_drained(input string name);
    int budget;
    budget = 100;
    while (exp_rsp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, DW'(exp_rsp_q.size()), '0);
  endtask

  // Monitor: compares every address issue and every response handshake.
  initial begin
    rsp_t          e;
    logic [TW-1:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.cache_addr_valid && bus.cache_addr_ready) begin
          check("issue_expected", DW'(exp_addr_q.size() > 0), DW'(1));
          if (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            check("issue_addr", DW'(bus.cache_addr_data), DW'(a));
          end
        end
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          check("rsp_expected", DW'(exp_rsp_q.size() > 0), DW'(1));
          if (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            check("rsp_route", DW'(bus.rsp_valid), DW'(NR'(1) << e.idx));
            check("rsp_data", bus.rsp_data, e.data);
          end
        end
      end
    end
  end

  // Cache frontend model: answers each accepted lookup one cycle later, in order.
  initial begin
    bit            ahs, dhs;
    logic [TW-1:0] a;
    bus.cache_data_valid = 1'b0;
    bus.cache_data_data  = '0;
    forever begin
      @(negedge clk);
      ahs = bus.cache_addr_valid && bus.cache_addr_ready;
      dhs = bus.cache_data_valid && bus.cache_data_ready;
      a   = bus.cache_addr_data;
      @(posedge clk);
      #1;
      if (dhs && pend_q.size() > 0) void'(pend_q.pop_front());
      if (ahs) pend_q.push_back(rsp_of(a));
      bus.cache_data_valid = resp_en && pend_q.size() > 0;
      bus.cache_data_data  = (pend_q.size() > 0) ? pend_q[0] : '0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expired, expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      taddr[i]        = TW'(48'h1000 + i);
      bus.req_addr[i] = taddr[i];
    end
    bus.req_valid        = '0;
    bus.rsp_ready        = '1;
    bus.cache_addr_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_req_ready", DW'(bus.req_ready), '0);
    check("rst_addr_valid", DW'(bus.cache_addr_valid), '0);
    check("rst_addr_data", DW'(bus.cache_addr_data), '0);
    check("rst_rsp_valid", DW'(bus.rsp_valid), '0);
    check("rst_data_ready", DW'(bus.cache_data_ready), '0);

    // All requesters valid: grant order 0,1,2,3,0
    resp_en = 1'b1;
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
    bus.req_valid = '1;
    wait_issued("rr_issue_done");
    bus.req_valid = '0;
    wait_rsp_drained("rr_rsp_done");
    repeat (2) tick();

    // Single requester 2, addr 0xABCD; afterwards rr_ptr must be 3
    taddr[2]        = 48'hABCD;
    bus.req_addr[2] = taddr[2];
    expect_grant(2);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", DW'(bus.req_ready), DW'(4'b0100));
    tick();
    bus.req_valid = '0;
    #1;
    check("issue_latency", DW'(bus.cache_addr_valid), DW'(1));
    check("issue_data_abcd", DW'(bus.cache_addr_data), DW'(48'hABCD));
    wait_issued("single_issue_done");
    wait_rsp_drained("single_rsp_done");
    expect_grant(3);
    bus.req_valid = '1;
    #1;
    check("rr_ptr_is_3", DW'(bus.req_ready), DW'(4'b1000));
    tick();
    bus.req_valid = '0;
    wait_issued("rr3_issue_done");
    wait_rsp_drained("rr3_rsp_done");

    // Outstanding limit: 4 issue, 5th waits for first response pop
    resp_en = 1'b0;
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3);
    bus.req_valid = '1;
    wait_issued("fill_issue_done");
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_blocks_grant", DW'(bus.req_ready), '0);
      check("full_no_issue", DW'(bus.cache_addr_valid), '0);
      tick();
    end
    resp_en = 1'b1;
    expect_grant(0);
    tick();
    #1;
    check("pop_cycle_ready_low", DW'(bus.req_ready), '0);
    check("pop_cycle_data_ready", DW'(bus.cache_data_ready), DW'(1));
    tick();
    #1;
    check("grant_after_pop", DW'(bus.req_ready), DW'(4'b0001));
    tick();
    bus.req_valid = '0;
    wait_issued("fifth_issue_done");
    wait_rsp_drained("full_rsp_done");

    // Head-of-line blocking: head=1 stalled, next head=3
    resp_en = 1'b0;
    expect_grant(1); expect_grant(3);
    bus.req_valid = 4'b1010;
    wait_issued("hol_issue_done");
    bus.req_valid = '0;
    bus.rsp_ready = 4'b1101;
    resp_en       = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hol_data_ready", DW'(bus.cache_data_ready), '0);
      check("hol_rsp_valid", DW'(bus.rsp_valid), DW'(4'b0010));
      tick();
    end
    bus.rsp_ready = '1;
    wait_rsp_drained("hol_rsp_done");

    // Reset mid-ISSUE with 2 outstanding
    resp_en = 1'b0;
    expect_grant(0); expect_grant(1);
    bus.req_valid = 4'b0011;
    wait_issued("pre_rst_issue_done");
    bus.cache_addr_ready = 1'b0;
    tick();
    #1;
    check("issue_held", DW'(bus.cache_addr_valid), DW'(1));
    rst           = 1'b1;
    bus.req_valid = '0;
    exp_rsp_q.delete();
    resp_en       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_req_ready", DW'(bus.req_ready), '0);
    check("midrst_addr_valid", DW'(bus.cache_addr_valid), '0);
    check("midrst_addr_data", DW'(bus.cache_addr_data), '0);
    check("midrst_rsp_valid", DW'(bus.rsp_valid), '0);
    check("midrst_data_ready", DW'(bus.cache_data_ready), '0);
    pend_q.delete();
    bus.cache_addr_ready = 1'b1;
    tick();
    expect_grant(0);
    bus.req_valid = '1;
    #1;
    check("post_rst_grant_0", DW'(bus.req_ready), DW'(4'b0001));
    tick();
    bus.req_valid = '0;
    wait_issued("post_rst_issue_done");
    wait_rsp_drained("post_rst_rsp_done");

`ifdef CACHE_ARB_STATS_EN
    // Stats: 3 full-stall cycles, then 10 grants to req 0
    rst = 1'b1;
    repeat (2) tick();
    rst     = 1'b0;
    resp_en = 1'b0;
    expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(1);
    bus.req_valid = 4'b1110;
    wait_issued("stat_fill_done");
    repeat (3) tick();
    bus.req_valid = '0;
    resp_en       = 1'b1;
    wait_rsp_drained("stat_fill_rsp_done");
    for (int i = 0; i < 10; i++) expect_grant(0);
    bus.req_valid = 4'b0001;
    wait_issued("stat_grants_done");
    bus.req_valid = '0;
    wait_rsp_drained("stat_grants_rsp_done");
    #1;
    check("stat_grant_cnt0", DW'(stat_grant_cnt[0]), DW'(10));
    check("stat_grant_cnt1", DW'(stat_grant_cnt[1]), DW'(2));
    check("stat_full_cycles", DW'(stat_full_cycles), DW'(3));
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
